tx_sequencer: RTL and testbench

Sequences the serial word transmitter. A button press (hit) starts a transmission of NWORDS 4-bit words, each fetched by index from an external word source. Each word goes out on tx as a UART-style frame: start bit, 4 data bits LSB first, stop bit. The block drives the word index (nom), the bit index (bit_idx) and the LED latch (le), and paces every bit with an internal baud tick.

---
 rtl/tx_seq_pkg.sv | 22 ++
 rtl/baud_tick_gen.sv | 27 ++
 rtl/tx_sequencer.sv | 110 +++++++++++
 tb/tb_tx_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_seq_pkg.sv
// Shared types and constants for the serial word transmit sequencer.
// Latency: n/a (types only). Backpressure: n/a. FRAME_BITS follows PARITY_EN.
// PARITY_EN adds one even-parity bit per frame.
package tx_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam int DATA_BITS = 4;
`ifdef PARITY_EN
    localparam int FRAME_BITS = 7;
`else
    localparam int FRAME_BITS = 6;
`endif
    localparam logic TX_IDLE = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period pacer: tick is high on the last cycle of every BAUD_DIV-cycle bit slot.
// Latency: tick asserts BAUD_DIV-1 cycles after restart or the previous tick.
// Backpressure: none; restart realigns the slot to the current cycle.
module baud_tick_gen #(
    parameter int BAUD_DIV = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = (cnt == 8'(BAUD_DIV - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/tx_sequencer.sv
// Sends NWORDS 4-bit words as start/4 data (LSB first)/[parity]/stop frames on a hit rise.
// Latency: busy 3 cycles after hit rises; frame 6*BAUD_DIV (7*BAUD_DIV with PARITY_EN) cycles.
// Backpressure: none; a hit while busy is dropped, clr aborts at once.
module tx_sequencer
    import tx_seq_pkg::*;
#(
    parameter int BAUD_DIV = 4,
    parameter int NWORDS   = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       hit,
    input  logic [3:0] word_in,
    output logic [3:0] nom,
    output logic [1:0] bit_idx,
    output logic [3:0] le,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] NOM_LAST = 4'(NWORDS - 1);

    state_t               state;
    state_t               state_nxt;
    logic                 restart;
    logic                 tick;
    logic [2:0]           hit_sync;
    logic                 hit_rise;
    logic                 last_word;
    logic [DATA_BITS-1:0] shreg;

    assign hit_rise  = hit_sync[1] & ~hit_sync[2];
    assign last_word = (nom == NOM_LAST);
    assign busy      = (state != IDLE);

    baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk     (clk),
        .clr     (clr),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (hit_rise) state_nxt = START;
            START: if (tick) state_nxt = DATA;
`ifdef PARITY_EN
            DATA:  if (tick && bit_idx == 2'd3) state_nxt = PAR;
            PAR:   if (tick) state_nxt = STOP;
`else
            DATA:  if (tick && bit_idx == 2'd3) state_nxt = STOP;
`endif
            STOP:  if (tick) state_nxt = last_word ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
        // Every bit slot starts counting from zero on state entry.
        restart = (state_nxt != state);
    end

    // tx is decoded from state so an async clr forces the line idle immediately.
    always_comb begin
        tx = TX_IDLE;
        case (state)
            START: tx = 1'b0;
            DATA:  tx = shreg[bit_idx];
`ifdef PARITY_EN
            PAR:   tx = ^shreg;
`endif
            default: tx = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hit_sync <= '0;
            nom      <= '0;
            bit_idx  <= '0;
            le       <= '0;
            shreg    <= '0;
            done     <= 1'b0;
        end else begin
            hit_sync <= {hit_sync[1:0], hit};
            done     <= (state == STOP) && tick && last_word;
            case (state)
                IDLE: if (hit_rise) nom <= '0;
                START: begin
                    if (tick) begin
                        shreg   <= word_in;
                        le      <= word_in;
                        bit_idx <= '0;
                    end
                end
                DATA: if (tick && bit_idx != 2'd3) bit_idx <= bit_idx + 2'd1;
                STOP: if (tick) nom <= last_word ? 4'd0 : nom + 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_sequencer.sv
// Randomised scoreboard bench for tx_sequencer: expected per-cycle line activity is queued
// when a transmission is launched and a negedge monitor compares it as the DUT runs.
module tb_tx_sequencer;

    localparam int BD = 4;
    localparam int NW = 3;
`ifdef PARITY_EN
    localparam int FB = 7;
`else
    localparam int FB = 6;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic       hit;
    logic [3:0] word_in;
    logic [3:0] nom;
    logic [1:0] bit_idx;
    logic [3:0] le;
    logic       tx;
    logic       busy;
    logic       done;

    logic [3:0] words [16];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic tx;
        int   nom;
        int   le;
        int   bidx;
        bit   chk_bidx;
        logic busy;
        logic done;
        bit   last;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    bit   active = 1'b0;
    int   last_word = 0;

    always #5 clk = ~clk;

    // External word source: combinational lookup by the index the DUT presents.
    assign word_in = words[nom];

    tx_sequencer #(.BAUD_DIV(BD), .NWORDS(NW)) dut (
        .clk     (clk),
        .clr     (clr),
        .hit     (hit),
        .word_in (word_in),
        .nom     (nom),
        .bit_idx (bit_idx),
        .le      (le),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Line value for bit slot k of a frame carrying word w.
    function automatic logic exp_bit(input logic [3:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= 4) return w[k-1];
        if (FB == 7 && k == 5) return ^w;
        return 1'b1;
    endfunction

    task automatic push_transmission();
        exp_t e;
        for (int w = 0; w < NW; w++) begin
            for (int k = 0; k < FB; k++) begin
                for (int c = 0; c < BD; c++) begin
                    e.tx       = exp_bit(words[w], k);
                    e.nom      = w;
                    e.le       = (k == 0) ? last_word : int'(words[w]);
                    e.bidx     = k - 1;
                    e.chk_bidx = (k >= 1 && k <= 4);
                    e.busy     = 1'b1;
                    e.done     = 1'b0;
                    e.last     = 1'b0;
                    q.push_back(e);
                end
            end
            last_word = int'(words[w]);
        end
        e.tx = 1'b1; e.nom = 0; e.le = last_word; e.bidx = 0; e.chk_bidx = 1'b0;
        e.busy = 1'b0; e.done = 1'b1; e.last = 1'b1;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (clr) begin
            active = 1'b0;
            q.delete();
            chk("rst_tx", tx, 1);
            chk("rst_nom", nom, 0);
            chk("rst_bit_idx", bit_idx, 0);
            chk("rst_le", le, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end else if (active || busy) begin
            if (q.size() == 0) begin
                chk("unexpected_busy", busy, 0);
                active = 1'b0;
            end else begin
                mon_e  = q.pop_front();
                active = 1'b1;
                chk("tx", tx, mon_e.tx);
                chk("busy", busy, mon_e.busy);
                chk("done", done, mon_e.done);
                chk("nom", nom, mon_e.nom);
                chk("le", le, mon_e.le);
                if (mon_e.chk_bidx) chk("bit_idx", bit_idx, mon_e.bidx);
                if (mon_e.last) active = 1'b0;
            end
        end else begin
            chk("idle_tx", tx, 1);
            chk("idle_done", done, 0);
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (q.size() == 0 && !active) break;
        end
        if (q.size() != 0 || active) begin
            chk("txn_timeout", q.size(), 0);
            q.delete();
            active = 1'b0;
        end
        #2;
    endtask

    task automatic run_txn(input int hit_len);
        push_transmission();
        hit = 1'b1;
        repeat (hit_len) @(posedge clk);
        #2 hit = 1'b0;
        wait_done();
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #2;
    endtask

    task automatic randomize_words();
        for (int i = 0; i < 16; i++) words[i] = 4'($urandom_range(0, 15));
    endtask

    initial begin
        clr = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 16; i++) words[i] = 4'h0;
        repeat (3) @(posedge clk);
        #2 clr = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        // Directed: first word 1010, then an incrementing pattern nom+5.
        words[0] = 4'b1010;
        words[1] = 4'h6;
        words[2] = 4'h7;
        run_txn(2);
        for (int i = 0; i < NW; i++) words[i] = 4'(i + 5);
        run_txn(1);
        words[0] = 4'b0111;
        run_txn(3);

        for (int t = 0; t < 4; t++) begin
            randomize_words();
            run_txn($urandom_range(1, 4));
        end

        // Hold hit high and bounce it while busy: only one transmission may result.
        randomize_words();
        push_transmission();
        hit = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (busy) break;
        end
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(2, 8)) @(posedge clk);
            #2 hit = ~hit;
        end
        wait_done();
        repeat (12) @(posedge clk);
        #2 hit = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        randomize_words();
        run_txn(2);

        // Abort during word 1, data bit 2.
        randomize_words();
        push_transmission();
        hit = 1'b1;
        repeat (2) @(posedge clk);
        #2 hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (nom == 4'd1 && bit_idx == 2'd2) break;
        end
        chk("abort_reached_bit2", bit_idx, 2);
        #2 clr = 1'b1;
        #1;
        chk("abort_tx_async", tx, 1);
        chk("abort_busy_async", busy, 0);
        last_word = 0;
        repeat (3) @(posedge clk);
        #2 clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        randomize_words();
        run_txn(1);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
